// File: rtl/matrix_loader.sv
// Byte-serial to group-word loader for the 16-element matrix memory: packs 4 elements per group, one write per row.
// Optional running element checksum enabled by defining MATRIX_LOADER_CHECKSUM_EN.
module matrix_loader #(
    parameter int WIDTH  = 8,
    parameter int GROUPS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    output logic                      write_en,
    output logic [1:0]                write_addr,
    output logic [GROUPS*WIDTH-1:0]   data_out,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state_r, state_next_s;
    logic [1:0]                elem_r, elem_next_s;
    logic [1:0]                group_r, group_next_s;
    logic [GROUPS*WIDTH-1:0]   lanes_r, lanes_next_s;
    logic                      xfer_s;
    logic                      write_en_r, busy_r, done_r;
    logic [1:0]                write_addr_r;
    logic [GROUPS*WIDTH-1:0]   data_out_r;

    assign in_ready = (state_r == LOAD);
    assign xfer_s   = in_valid && (state_r == LOAD);

    // Next-state, counter and lane-buffer decode
    always_comb begin
        state_next_s = state_r;
        elem_next_s  = elem_r;
        group_next_s = group_r;
        lanes_next_s = lanes_r;
        if (xfer_s) begin
            lanes_next_s[int'(elem_r)*WIDTH +: WIDTH] = in_data;
        end else begin
            lanes_next_s = lanes_r;
        end
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_next_s = LOAD;
                    elem_next_s  = 2'd0;
                    group_next_s = 2'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next_s = IDLE;
                end else if (xfer_s) begin
                    elem_next_s = elem_r + 2'd1;
                    if (elem_r == 2'd3) begin
                        state_next_s = WRITE;
                    end else begin
                        state_next_s = LOAD;
                    end
                end else begin
                    state_next_s = LOAD;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_next_s = IDLE;
                end else if (group_r == 2'd3) begin
                    state_next_s = DONE;
                end else begin
                    group_next_s = group_r + 2'd1;
                    elem_next_s  = 2'd0;
                    state_next_s = LOAD;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; the packed word is captured as the FSM enters WRITE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            elem_r       <= 2'd0;
            group_r      <= 2'd0;
            lanes_r      <= '0;
            write_en_r   <= 1'b0;
            write_addr_r <= 2'd0;
            data_out_r   <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            elem_r     <= elem_next_s;
            group_r    <= group_next_s;
            lanes_r    <= lanes_next_s;
            write_en_r <= (state_next_s == WRITE);
            busy_r     <= (state_next_s != IDLE);
            done_r     <= (state_next_s == DONE);
            if (state_next_s == WRITE) begin
                write_addr_r <= group_r;
                data_out_r   <= lanes_next_s;
            end
        end
    end

    assign write_en   = write_en_r;
    assign write_addr = write_addr_r;
    assign data_out   = data_out_r;
    assign busy       = busy_r;
    assign done       = done_r;

`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [15:0] checksum_r;

    // Running modular sum, cleared when a load starts and frozen once it completes
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_r <= 16'h0000;
        end else if (state_r == IDLE && state_next_s == LOAD) begin
            checksum_r <= 16'h0000;
        end else if (xfer_s && !abort) begin
            checksum_r <= checksum_r + 16'(in_data);
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = 16'h0000;
`endif

endmodule
